// File: rtl/rv32i_instr_encoder.sv
// Packs decoded RV32I instruction fields into 32-bit words and streams them into
// instruction RAM through a small FIFO and a write port with backpressure.
module rv32i_instr_encoder #(
    parameter int unsigned             ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
    parameter int unsigned             DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              mem_wr_en,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [15:0]       wr_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_IL = 7'b0000011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_UA = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JI = 7'b1100111;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [31:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full, fifo_empty;
    logic             accept, push, pop, session_start;
    logic [31:0]      word;
    logic             known;

    assign fifo_full     = (count == CNT_W'(DEPTH));
    assign fifo_empty    = (count == '0);
    assign s_ready       = (state_q == LOAD) && !fifo_full;
    assign accept        = s_valid && s_ready;
    assign push          = accept && known;
    assign pop           = !fifo_empty && mem_ready;
    assign session_start = (state_q == IDLE) && start;

    assign mem_wr_en = !fifo_empty;
    assign mem_wdata = fifo_empty ? 32'h0 : fifo_mem[rptr];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    // Field packing per instruction format; unknown opcodes are flagged, not encoded.
    always_comb begin
        word  = 32'h0;
        known = 1'b1;
        case (op)
            OP_R:  word = {funct7, rs2, rs1, funct3, rd, op};
            OP_I: begin
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    word = {funct7, imm[4:0], rs1, funct3, rd, op};
                else
                    word = {imm[11:0], rs1, funct3, rd, op};
            end
            OP_IL: word = {imm[11:0], rs1, funct3, rd, op};
            OP_JI: word = {imm[11:0], rs1, 3'b000, rd, op};
            OP_S:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            OP_B:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
            OP_U,
            OP_UA: word = {imm[31:12], rd, op};
            OP_J:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (accept && s_last) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Storage array carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr <= BASE_ADDR;
            wr_count <= 16'h0;
            illegal  <= 1'b0;
        end else begin
            if (session_start)  mem_addr <= BASE_ADDR;
            else if (pop)       mem_addr <= mem_addr + ADDR_W'(4);

            if (session_start)                     wr_count <= 16'h0;
            else if (pop && wr_count != 16'hFFFF)  wr_count <= wr_count + 16'd1;

            if (session_start)          illegal <= 1'b0;
            else if (accept && !known)  illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Scoreboard bench for rv32i_instr_encoder: directed instructions with hand-encoded
// expected words; a monitor checks every accepted memory write in order.
module tb_rv32i_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, s_valid, s_ready, s_last;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        mem_wr_en, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic        busy, done, illegal;
    logic [15:0] wr_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          writes   = 0;
    logic [63:0] sb_q [$];
    logic [63:0] mon_e;
    logic [31:0] exp_addr;
    int          w_before;

    always #5 clk = ~clk;

    rv32i_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .op(op), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .mem_wr_en(mem_wr_en), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .illegal(illegal), .wr_count(wr_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pops one expected {addr,data} for every write the memory accepts.
    always @(negedge clk) begin
        if (reset_n && mem_wr_en && mem_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = sb_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(mon_e[63:32]));
                check("wr_data", 64'(mem_wdata), 64'(mon_e[31:0]));
            end
            writes++;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_addr = 32'h0;
    endtask

    task automatic send(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] im, input logic last,
                        input logic has_word, input logic [31:0] exp_w);
        int t = 0;
        op = o; funct3 = f3; funct7 = f7; rd = d; rs1 = a; rs2 = b; imm = im;
        s_last = last; s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got s_ready 0 expected 1 within 100 cycles");
        end else begin
            if (has_word) begin
                sb_q.push_back({exp_addr, exp_w});
                exp_addr = exp_addr + 32'd4;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (!done && t < 100) begin
            t++;
            @(negedge clk);
        end
        check("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; mem_ready = 1'b0;
        op = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        exp_addr = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single R-type; write must be visible the cycle after accept.
        mem_ready = 1'b1;
        do_start();
        @(negedge clk);
        check("load_s_ready", 64'(s_ready), 64'd1);
        check("load_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        send(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 32'h002081B3);
        check("wr_en_after_accept", 64'(mem_wr_en), 64'd1);
        wait_done();
        check("count_add", 64'(wr_count), 64'd1);

        // addi then sw.
        do_start();
        send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093);
        send(7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 1'b1, 32'h0020A423);
        wait_done();
        check("count_addi_sw", 64'(wr_count), 64'd2);

        // B, J, U, JI (funct3 forced to 000), IL, UA (low imm bits ignored).
        do_start();
        send(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFE208EE3);
        send(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0, 1'b1, 32'h008000EF);
        send(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b1, 32'h123452B7);
        send(7'h67, 3'd7, 7'h00, 5'd1, 5'd2, 5'd0, 32'd4, 1'b0, 1'b1, 32'h004100E7);
        send(7'h03, 3'd2, 7'h00, 5'd6, 5'd2, 5'd0, 32'd12, 1'b0, 1'b1, 32'h00C12303);
        send(7'h17, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'hABCDE123, 1'b1, 1'b1, 32'hABCDE397);
        wait_done();
        check("count_formats", 64'(wr_count), 64'd6);

        // Backpressure: FIFO fills at 4, head held stable, then drains in order.
        do_start();
        mem_ready = 1'b0;
        send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 1'b1, 32'h00100093);
        send(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 1'b1, 32'h00200113);
        send(7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, 1'b1, 32'h00300193);
        send(7'h13, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'd4, 1'b0, 1'b1, 32'h00400213);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_s_ready", 64'(s_ready), 64'd0);
            check("hold_wr_en", 64'(mem_wr_en), 64'd1);
            check("hold_addr", 64'(mem_addr), 64'd0);
            check("hold_data", 64'(mem_wdata), 64'h00100093);
        end
        check("hold_count", 64'(wr_count), 64'd0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        send(7'h13, 3'd5, 7'h20, 5'd5, 5'd1, 5'd0, 32'd3, 1'b1, 1'b1, 32'h4030D293);
        wait_done();
        check("count_bp", 64'(wr_count), 64'd5);

        // Unknown opcode with s_last: no write, sticky illegal, session still ends.
        do_start();
        w_before = writes;
        send(7'h7F, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("illegal_set", 64'(illegal), 64'd1);
        @(posedge clk); #1;
        wait_done();
        check("illegal_sticky", 64'(illegal), 64'd1);
        check("illegal_no_write", 64'(writes), 64'(w_before));
        check("illegal_count", 64'(wr_count), 64'd0);
        do_start();
        @(negedge clk);
        check("start_clears_illegal", 64'(illegal), 64'd0);
        check("start_clears_count", 64'(wr_count), 64'd0);
        @(posedge clk); #1;

        // Reset mid-session with three words queued.
        mem_ready = 1'b0;
        send(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h002081B3);
        send(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h402081B3);
        send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093);
        @(negedge clk);
        check("queued_wr_en", 64'(mem_wr_en), 64'd1);
        #2;
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_wr_en", 64'(mem_wr_en), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_s_ready", 64'(s_ready), 64'd0);
        check("midrst_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        do_start();
        send(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 32'h002081B3);
        wait_done();
        check("post_rst_count", 64'(wr_count), 64'd1);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
